// File: rtl/bcp_clause_engine.sv
// Clause-serial Boolean constraint propagation engine.
// Scans stored clauses against a latched assignment snapshot.
module bcp_clause_engine #(
    parameter int VAR_NUM    = 8,
    parameter int CLAUSE_NUM = 4,
    parameter int VIDX_W     = $clog2(VAR_NUM),
    parameter int CIDX_W     = $clog2(CLAUSE_NUM)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CIDX_W-1:0] cfg_idx,
    input  logic [VAR_NUM-1:0] cfg_mask,
    input  logic [VAR_NUM-1:0] cfg_type,
    input  logic              start,
    input  logic [VAR_NUM-1:0] assignment,
    input  logic [VAR_NUM-1:0] free,
    output logic              busy,
    output logic              imp_valid,
    input  logic              imp_ready,
    output logic [VIDX_W-1:0] imp_var,
    output logic              imp_value,
    output logic [CIDX_W-1:0] imp_clause,
    output logic              conflict,
    output logic [CIDX_W-1:0] conflict_clause,
    output logic              done,
    output logic [CIDX_W:0]   unit_count
);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

    state_t              state;
    logic [VAR_NUM-1:0]  mask_q [CLAUSE_NUM];
    logic [VAR_NUM-1:0]  type_q [CLAUSE_NUM];
    logic [VAR_NUM-1:0]  snap_a;
    logic [VAR_NUM-1:0]  snap_f;
    logic [CIDX_W-1:0]   idx;

    logic [VAR_NUM-1:0]  cur_mask;
    logic [VAR_NUM-1:0]  cur_type;
    logic [VAR_NUM-1:0]  true_lits;
    logic [VAR_NUM-1:0]  free_lits;
    logic                is_unit;
    logic                is_last;
    logic [VIDX_W-1:0]   unit_var;

    always_comb begin
        cur_mask  = mask_q[idx];
        cur_type  = type_q[idx];
        true_lits = cur_mask & ~snap_f & ~(snap_a ^ cur_type);
        free_lits = cur_mask & snap_f;
        is_unit   = (free_lits != '0) &&
                    ((free_lits & (free_lits - VAR_NUM'(1))) == '0);
        is_last   = (idx == CIDX_W'(CLAUSE_NUM - 1));
        unit_var  = '0;
        for (int i = 0; i < VAR_NUM; i++) begin
            if (free_lits[i]) unit_var = VIDX_W'(i);
        end
    end

    // Clause store is frozen while a scan is running.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < CLAUSE_NUM; k++) begin
                mask_q[k] <= '0;
                type_q[k] <= '0;
            end
        end else if (cfg_we && (state == IDLE || state == DONE)) begin
            mask_q[cfg_idx] <= cfg_mask;
            type_q[cfg_idx] <= cfg_type;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            snap_a          <= '0;
            snap_f          <= '0;
            idx             <= '0;
            busy            <= 1'b0;
            imp_valid       <= 1'b0;
            imp_var         <= '0;
            imp_value       <= 1'b0;
            imp_clause      <= '0;
            conflict        <= 1'b0;
            conflict_clause <= '0;
            done            <= 1'b0;
            unit_count      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        snap_a          <= assignment;
                        snap_f          <= free;
                        conflict        <= 1'b0;
                        conflict_clause <= '0;
                        unit_count      <= '0;
                        idx             <= '0;
                        busy            <= 1'b1;
                        state           <= SCAN;
                    end
                end
                SCAN: begin
                    if (cur_mask != '0 && true_lits == '0 && free_lits == '0) begin
                        conflict        <= 1'b1;
                        conflict_clause <= idx;
                        busy            <= 1'b0;
                        done            <= 1'b1;
                        state           <= DONE;
                    end else if (cur_mask != '0 && true_lits == '0 && is_unit) begin
                        imp_valid  <= 1'b1;
                        imp_var    <= unit_var;
                        imp_value  <= cur_type[unit_var];
                        imp_clause <= idx;
                        state      <= EMIT;
                    end else if (is_last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + CIDX_W'(1);
                    end
                end
                EMIT: begin
                    if (imp_ready) begin
                        // Fold the accepted implication into the snapshot.
                        snap_f[imp_var] <= 1'b0;
                        snap_a[imp_var] <= imp_value;
                        unit_count      <= unit_count + (CIDX_W + 1)'(1);
                        imp_valid       <= 1'b0;
                        if (is_last) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx   <= idx + CIDX_W'(1);
                            state <= SCAN;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcp_clause_engine.sv
// Randomised self-checking bench for bcp_clause_engine.
// Expected implications come from a clause-by-clause reference model.
module tb_bcp_clause_engine;

    localparam int VN = 8;
    localparam int CN = 4;
    localparam int VW = 3;
    localparam int CW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_we = 1'b0;
    logic [CW-1:0] cfg_idx = '0;
    logic [VN-1:0] cfg_mask = '0;
    logic [VN-1:0] cfg_type = '0;
    logic          start = 1'b0;
    logic [VN-1:0] assignment = '0;
    logic [VN-1:0] free = '0;
    logic          busy;
    logic          imp_valid;
    logic          imp_ready = 1'b0;
    logic [VW-1:0] imp_var;
    logic          imp_value;
    logic [CW-1:0] imp_clause;
    logic          conflict;
    logic [CW-1:0] conflict_clause;
    logic          done;
    logic [CW:0]   unit_count;

    bcp_clause_engine #(.VAR_NUM(VN), .CLAUSE_NUM(CN)) dut (
        .clock(clock), .reset(reset),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_mask(cfg_mask), .cfg_type(cfg_type),
        .start(start), .assignment(assignment), .free(free),
        .busy(busy), .imp_valid(imp_valid), .imp_ready(imp_ready),
        .imp_var(imp_var), .imp_value(imp_value), .imp_clause(imp_clause),
        .conflict(conflict), .conflict_clause(conflict_clause),
        .done(done), .unit_count(unit_count)
    );

    always #5 clock = ~clock;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int v;
        int val;
        int cl;
    } imp_t;

    logic [VN-1:0] m_mask [CN];
    logic [VN-1:0] m_type [CN];
    imp_t          exp_q [$];
    int            exp_conf;
    int            exp_cc;
    int            exp_stop;
    int            exp_units;

    // Clause-by-clause propagation over a private copy of the assignment.
    task automatic model(input logic [VN-1:0] a_in, input logic [VN-1:0] f_in);
        logic [VN-1:0] a;
        logic [VN-1:0] f;
        int nfree;
        int fv;
        bit sat;
        a = a_in;
        f = f_in;
        exp_q.delete();
        exp_conf = 0;
        exp_cc = 0;
        exp_stop = CN;
        for (int k = 0; k < CN; k++) begin
            nfree = 0;
            fv = 0;
            sat = 0;
            if (m_mask[k] == '0) continue;
            for (int v = 0; v < VN; v++) begin
                if (m_mask[k][v]) begin
                    if (f[v]) begin
                        nfree++;
                        fv = v;
                    end else if (a[v] == m_type[k][v]) begin
                        sat = 1;
                    end
                end
            end
            if (sat) continue;
            if (nfree == 0) begin
                exp_conf = 1;
                exp_cc = k;
                exp_stop = k + 1;
                break;
            end
            if (nfree == 1) begin
                exp_q.push_back('{fv, int'(m_type[k][fv]), k});
                f[fv] = 1'b0;
                a[fv] = m_type[k][fv];
            end
        end
        exp_units = exp_q.size();
    endtask

    task automatic cfg_wr(input int i, input logic [VN-1:0] m,
                          input logic [VN-1:0] t);
        @(negedge clock);
        cfg_we = 1'b1;
        cfg_idx = CW'(i);
        cfg_mask = m;
        cfg_type = t;
        @(negedge clock);
        cfg_we = 1'b0;
        m_mask[i] = m;
        m_type[i] = t;
    endtask

    // stall_mode < 0 picks a random stall per implication.
    task automatic run_scan(input logic [VN-1:0] a, input logic [VN-1:0] f,
                            input int stall_mode, input bit poke);
        int c;
        int stall;
        int total_stall;
        bit fin;
        model(a, f);
        @(negedge clock);
        assignment = a;
        free = f;
        start = 1'b1;
        imp_ready = 1'b0;
        c = 0;
        stall = -1;
        total_stall = 0;
        fin = 0;
        while (!fin && c < 300) begin
            @(negedge clock);
            c++;
            start = 1'b0;
            cfg_we = 1'b0;
            imp_ready = 1'b0;
            if (done) begin
                chk("done_cycle", c, exp_stop + exp_units + total_stall + 1);
                chk("conflict", conflict, exp_conf);
                chk("conflict_clause", conflict_clause, exp_cc);
                chk("unit_count", unit_count, exp_units);
                chk("busy_done", busy, 0);
                chk("valid_done", imp_valid, 0);
                chk("missing_imps", exp_q.size(), 0);
                fin = 1;
            end else begin
                chk("busy", busy, 1);
                if (imp_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_imp", 1, 0);
                    end else begin
                        chk("imp_var", imp_var, exp_q[0].v);
                        chk("imp_value", imp_value, exp_q[0].val);
                        chk("imp_clause", imp_clause, exp_q[0].cl);
                    end
                    if (stall < 0)
                        stall = (stall_mode < 0) ? int'($urandom_range(0, 3)) : stall_mode;
                    if (stall > 0) begin
                        stall--;
                        total_stall++;
                        if (poke) begin
                            cfg_we = 1'b1;
                            cfg_idx = CW'($urandom);
                            cfg_mask = VN'($urandom);
                            cfg_type = VN'($urandom);
                        end
                    end else begin
                        imp_ready = 1'b1;
                        stall = -1;
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                    end
                end
            end
        end
        if (!fin) chk("timeout", 0, 1);
    endtask

    task automatic check_zero(input string tag);
        chk(tag, {busy, imp_valid, imp_var, imp_value, imp_clause,
                  conflict, conflict_clause, done, unit_count}, 0);
    endtask

    initial begin
        bit seen;
        for (int k = 0; k < CN; k++) begin
            m_mask[k] = '0;
            m_type[k] = '0;
        end
        #2;
        check_zero("reset_outputs");
        @(negedge clock);
        reset = 1'b0;

        // Single unit, then conflict, then backpressure with ignored writes.
        cfg_wr(0, 8'h07, 8'h05);
        run_scan(8'h02, 8'h04, 0, 0);
        run_scan(8'h02, 8'h00, 0, 0);
        run_scan(8'h02, 8'h04, 5, 1);

        // Chained propagation and propagation-induced conflict.
        cfg_wr(1, 8'h0C, 8'h00);
        run_scan(8'h02, 8'h0C, 0, 0);
        cfg_wr(1, 8'h04, 8'h00);
        run_scan(8'h02, 8'h04, 0, 0);

        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < CN; k++) begin
                if ($urandom_range(0, 4) == 0)
                    cfg_wr(k, 8'h00, VN'($urandom));
                else
                    cfg_wr(k, VN'($urandom & $urandom), VN'($urandom));
            end
            run_scan(VN'($urandom), VN'($urandom | $urandom), -1, 1);
        end

        // Reset while an implication is waiting.
        cfg_wr(0, 8'h07, 8'h05);
        cfg_wr(1, 8'h00, 8'h00);
        cfg_wr(2, 8'h00, 8'h00);
        cfg_wr(3, 8'h00, 8'h00);
        @(negedge clock);
        assignment = 8'h02;
        free = 8'h04;
        start = 1'b1;
        imp_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock);
            start = 1'b0;
            seen = imp_valid;
        end
        chk("emit_reached", seen, 1);
        #2;
        reset = 1'b1;
        #1;
        check_zero("midop_reset");
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < CN; k++) begin
            m_mask[k] = '0;
            m_type[k] = '0;
        end
        run_scan(VN'($urandom), VN'($urandom), 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/bcp_clause_engine.md
Name: bcp_clause_engine

Overview:
- Parametrised multi-clause Boolean Constraint Propagation engine for the hardware SAT datapath.
- Holds CLAUSE_NUM clauses over VAR_NUM variables and scans them one clause per cycle against a latched assignment snapshot.
- Reports each unit implication over a valid/ready channel, or reports the first conflict.
- Accepted implications are folded back into the local snapshot, so later clauses in the same scan see them.

Parameters:
- VAR_NUM, 8, number of variables / literal slots per clause
- CLAUSE_NUM, 4, number of clause slots
- VIDX_W, $clog2(VAR_NUM), variable index width (derived)
- CIDX_W, $clog2(CLAUSE_NUM), clause index width (derived)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cfg_we  in  1  write clause slot cfg_idx
- cfg_idx  in  CIDX_W  clause slot to write
- cfg_mask  in  VAR_NUM  1 = variable present in clause
- cfg_type  in  VAR_NUM  1 = positive literal, 0 = negated literal
- start  in  1  begin scan; latches assignment/free
- assignment  in  VAR_NUM  variable values (meaningful where free=0)
- free  in  VAR_NUM  1 = variable unassigned
- busy  out  1  scan in progress
- imp_valid  out  1  implication available
- imp_ready  in  1  consumer accepts implication
- imp_var  out  VIDX_W  implied variable index
- imp_value  out  1  implied value
- imp_clause  out  CIDX_W  source clause
- conflict  out  1  sticky conflict flag for the current scan
- conflict_clause  out  CIDX_W  first falsified clause
- done  out  1  one-cycle end-of-scan pulse
- unit_count  out  CIDX_W+1  implications accepted in this scan

Behaviour:
- Reset (async, any state):
  - FSM to IDLE.
  - All outputs 0.
  - All clause masks/types cleared; mask=0 means the slot is disabled.
  - Snapshot registers cleared.
- Literal evaluation for clause k over the snapshot (a, f):
  - true_lits = mask & ~f & ~(a ^ type)
  - free_lits = mask & f
- Clause classification, in priority order:
  - mask==0: skip.
  - |true_lits: satisfied, skip.
  - free_lits==0: conflict.
  - exactly one free_lits bit: unit. imp_var = that index, imp_value = type[imp_var].
  - two or more free bits: skip.
- FSM states: IDLE, SCAN, EMIT, DONE.
- IDLE:
  - start=1 latches assignment/free into the snapshot and clears conflict, conflict_clause and unit_count.
  - Sets idx=0, goes to SCAN.
  - busy=1 from the next cycle.
- SCAN, one clause per cycle:
  - Unit: register imp_* fields, go to EMIT (imp_valid high the next cycle).
  - Conflict: conflict<=1, conflict_clause<=idx, go to DONE; the rest of the scan is aborted.
  - Skip: if idx==CLAUSE_NUM-1 go to DONE, else idx+1.
- EMIT:
  - imp_valid held, and imp_var/imp_value/imp_clause held stable, until imp_ready=1.
  - On the handshake cycle:
    - f[imp_var]<=0, a[imp_var]<=imp_value, unit_count+1.
    - imp_valid<=0.
    - Go to SCAN at idx+1, or to DONE if idx was last.
  - The handshake may occur in the first EMIT cycle; the minimum stall is 1 cycle.
- DONE:
  - done=1 for exactly one cycle, busy=0, then IDLE.
  - conflict, conflict_clause and unit_count hold until the next start.
- Latency:
  - Start at cycle 0 with no units and no conflict gives SCAN in cycles 1..CLAUSE_NUM and done at cycle CLAUSE_NUM+1.
  - Each unit adds 1 + (cycles imp_ready is low).
- Clause writes:
  - cfg_we is honoured only in IDLE/DONE. It is ignored (dropped) while busy.
  - A write in the same cycle as start: the write is applied and the scan uses the old contents for that slot only if idx has already passed it. In practice the scan always sees the new value, since slot 0 is evaluated the next cycle.
- start while busy: ignored.
- Duplicate or contradictory implications:
  - Once an implication is accepted, the variable is no longer free.
  - A later clause needing the opposite value classifies as conflict.
  - A clause needing the same value classifies as satisfied.
- Clauses already scanned are not revisited; there is no fixpoint iteration (the controller re-issues start).

Test Plan (VAR_NUM=8, CLAUSE_NUM=4):
1. Single unit:
   - Stimulus: clause0 mask=0000_0111, type=0000_0101; start with assignment=0000_0010, free=0000_0100; imp_ready=1.
   - Response: imp_valid at cycle 2 with imp_var=2, imp_value=1, imp_clause=0; done at cycle 6; unit_count=1; conflict=0.
2. Conflict:
   - Stimulus: same clause, free=0000_0000, assignment=0000_0010.
   - Response: conflict=1, conflict_clause=0, done at cycle 2, imp_valid never asserted, unit_count=0.
3. Chained propagation:
   - Stimulus: add clause1 mask=0000_1100, type=0000_0000; free=0000_1100, assignment=0000_0010.
   - Response: implications (var2, 1, clause0) then (var3, 0, clause1); unit_count=2; no conflict.
4. Propagation-induced conflict:
   - Stimulus: clause1 mask=0000_0100, type=0000_0000, with the scenario-1 inputs.
   - Response: implication var2=1 accepted, then conflict=1, conflict_clause=1.
5. Backpressure:
   - Stimulus: scenario 1 with imp_ready low for 5 cycles.
   - Response: imp_valid and all fields stable, busy=1, cfg_we writes during the stall are ignored, done at cycle 11.
6. Reset mid-operation:
   - Stimulus: assert reset while in EMIT.
   - Response: all outputs 0 immediately. A following start with no config gives done at cycle 5 with no implications and no conflict.
